// File: rtl/wb_arb_if.sv
// wb_arb_if: bundle of the writeback-stage bus.
//   Result channels : ch_valid / ch_rd / ch_data in, ch_ready out (per channel)
//   Pipeline        : flush in
//   ECALL           : ecall_valid / ecall_pc in, ecall_ready / ecall_start out,
//                     ecall_done / ecall_ret in
//   Retire          : rf_we / rf_rd / rf_data, redirect_valid / redirect_pc,
//                     retired_cnt out
// Modport slave is the writeback stage; master is the producer/consumer side.
interface wb_arb_if #(
  parameter int NCH     = 3,
  parameter int XLEN    = 64,
  parameter int REGBITS = 5,
  parameter int PCW     = 32
);
  logic [NCH-1:0]         ch_valid;
  logic [NCH*REGBITS-1:0] ch_rd;
  logic [NCH*XLEN-1:0]    ch_data;
  logic [NCH-1:0]         ch_ready;
  logic                   flush;
  logic                   ecall_valid;
  logic [PCW-1:0]         ecall_pc;
  logic                   ecall_ready;
  logic                   ecall_start;
  logic                   ecall_done;
  logic [XLEN-1:0]        ecall_ret;
  logic                   rf_we;
  logic [REGBITS-1:0]     rf_rd;
  logic [XLEN-1:0]        rf_data;
  logic                   redirect_valid;
  logic [PCW-1:0]         redirect_pc;
  logic [63:0]            retired_cnt;

  modport slave (
    input  ch_valid, ch_rd, ch_data, flush, ecall_valid, ecall_pc,
           ecall_done, ecall_ret,
    output ch_ready, ecall_ready, ecall_start, rf_we, rf_rd, rf_data,
           redirect_valid, redirect_pc, retired_cnt
  );

  modport master (
    output ch_valid, ch_rd, ch_data, flush, ecall_valid, ecall_pc,
           ecall_done, ecall_ret,
    input  ch_ready, ecall_ready, ecall_start, rf_we, rf_rd, rf_data,
           redirect_valid, redirect_pc, retired_cnt
  );
endinterface

// File: rtl/wb_arb.sv
// wb_arb: multi-channel writeback stage.
//   Round-robin arbitration of NCH result channels into one registered
//   register-file write per cycle; ECALL sequencing (drain, start pulse,
//   wait for handler, write a0, redirect fetch to pc+4); pipeline flush.
// Ports: clk, rst (synchronous, active-high), bus (wb_arb_if.slave).
// Optional: define WB_RETIRE_CNT_EN to build the 64-bit retirement counter;
//   otherwise retired_cnt is tied to zero.
module wb_arb #(
  parameter int NCH     = 3,
  parameter int XLEN    = 64,
  parameter int REGBITS = 5,
  parameter int PCW     = 32
) (
  input logic     clk,
  input logic     rst,
  wb_arb_if.slave bus
);
  localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] ECALL_WAIT = 1'b1;

  logic [0:0]         state;
  logic [PTRW-1:0]    rr_ptr;
  logic [PCW-1:0]     pc_q;
  logic               rf_we_q, start_q, redir_q;
  logic [REGBITS-1:0] rf_rd_q;
  logic [XLEN-1:0]    rf_data_q;
  logic [PCW-1:0]     redir_pc_q;

  logic               grant_vld;
  logic [PTRW-1:0]    grant, next_ptr;
  logic [REGBITS-1:0] g_rd;
  logic [XLEN-1:0]    g_data;
  logic [NCH-1:0]     ch_ready_c;
  logic               ecall_ready_c;

  // First valid channel starting at rr_ptr, wrapping modulo NCH.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!grant_vld && bus.ch_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = PTRW'(idx);
      end
    end
  end

  assign next_ptr = (grant == PTRW'(NCH - 1)) ? '0 : grant + PTRW'(1);
  assign g_rd     = bus.ch_rd[int'(grant)*REGBITS +: REGBITS];
  assign g_data   = bus.ch_data[int'(grant)*XLEN +: XLEN];

  // Flush consumes every presented result and any presented ECALL; an ECALL
  // is only taken once all older channel results have drained.
  always_comb begin
    ch_ready_c    = '0;
    ecall_ready_c = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.flush) begin
        ch_ready_c    = bus.ch_valid;
        ecall_ready_c = bus.ecall_valid;
      end else begin
        if (grant_vld) ch_ready_c[grant] = 1'b1;
        ecall_ready_c = bus.ecall_valid && (bus.ch_valid == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      pc_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
      start_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      start_q <= 1'b0;
      redir_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.flush) begin
            if (grant_vld) begin
              rr_ptr <= next_ptr;
              // x0 writes are consumed but never reach the register file
              if (g_rd != '0) begin
                rf_we_q   <= 1'b1;
                rf_rd_q   <= g_rd;
                rf_data_q <= g_data;
              end
            end else if (bus.ecall_valid) begin
              pc_q    <= bus.ecall_pc;
              start_q <= 1'b1;
              state   <= ECALL_WAIT;
            end
          end
        end
        default: begin
          if (bus.ecall_done) begin
            rf_we_q    <= 1'b1;
            rf_rd_q    <= REGBITS'(10);
            rf_data_q  <= bus.ecall_ret;
            redir_q    <= 1'b1;
            redir_pc_q <= pc_q + PCW'(4);
            state      <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic        retire;
  logic [63:0] cnt_q;
  assign retire = (state == IDLE && !bus.flush && grant_vld) ||
                  (state == ECALL_WAIT && bus.ecall_done);
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 64'd1;
  end
  assign bus.retired_cnt = cnt_q;
`else
  assign bus.retired_cnt = '0;
`endif

  assign bus.ch_ready       = ch_ready_c;
  assign bus.ecall_ready    = ecall_ready_c;
  assign bus.ecall_start    = start_q;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_data        = rf_data_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
endmodule
